fractcam_upd: RTL and testbench



---
 rtl/fractcam_pkg.sv | 20 ++
 rtl/fractcam_upd_if.sv | 37 +++
 rtl/fractcam_row_match.sv | 22 ++
 rtl/fractcam_upd.sv | 130 +++++++++++++
 tb/tb_fractcam_upd.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fractcam_pkg.sv
// rtl/fractcam_pkg.sv - shared constants, FSM encoding and slice helpers for the FracTCAM update path
package fractcam_pkg;

  localparam int SLICE_W = 6;
  localparam int ROWS    = 64;

  // Padding bits beyond KEY_WIDTH are don't-care so they never block a match.
  localparam logic MASK_PAD = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } upd_state_t;

  function automatic int slices_of(input int key_width);
    return (key_width + SLICE_W - 1) / SLICE_W;
  endfunction

endpackage

// File: rtl/fractcam_upd_if.sv
// rtl/fractcam_upd_if.sv - update request and match-table write bundle
// Optional FRACTCAM_UPD_SHADOW_EN adds the shadow read port.
interface fractcam_upd_if
  import fractcam_pkg::*;
#(
  parameter int KEY_WIDTH = 30,
  parameter int DEPTH     = 64,
  parameter int IDX_WIDTH = $clog2(DEPTH),
  parameter int SLICES    = (KEY_WIDTH + 5) / 6
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [IDX_WIDTH-1:0] wr_index;
  logic [KEY_WIDTH-1:0] wr_key;
  logic [KEY_WIDTH-1:0] wr_mask;
  logic                 wr_entry_en;
  logic                 mt_we;
  logic [SLICE_W-1:0]   mt_row;
  logic [IDX_WIDTH-1:0] mt_col;
  logic [SLICES-1:0]    mt_data;
  logic                 busy;
  logic                 done;
`ifdef FRACTCAM_UPD_SHADOW_EN
  logic [IDX_WIDTH-1:0] rd_index;
  logic [2*KEY_WIDTH:0] rd_entry;

  modport master (output wr_valid, wr_index, wr_key, wr_mask, wr_entry_en, rd_index,
                  input  wr_ready, mt_we, mt_row, mt_col, mt_data, busy, done, rd_entry);
  modport slave  (input  wr_valid, wr_index, wr_key, wr_mask, wr_entry_en, rd_index,
                  output wr_ready, mt_we, mt_row, mt_col, mt_data, busy, done, rd_entry);
`else
  modport master (output wr_valid, wr_index, wr_key, wr_mask, wr_entry_en,
                  input  wr_ready, mt_we, mt_row, mt_col, mt_data, busy, done);
  modport slave  (input  wr_valid, wr_index, wr_key, wr_mask, wr_entry_en,
                  output wr_ready, mt_we, mt_row, mt_col, mt_data, busy, done);
`endif
endinterface

// File: rtl/fractcam_row_match.sv
// rtl/fractcam_row_match.sv - per-slice column bit for one LUTRAM row address
module fractcam_row_match
  import fractcam_pkg::*;
#(
  parameter int SLICES = 5
) (
  input  logic [SLICE_W-1:0]        i_row,
  input  logic [SLICES*SLICE_W-1:0] i_key,
  input  logic [SLICES*SLICE_W-1:0] i_mask,
  input  logic                      i_en,
  output logic [SLICES-1:0]         o_bits
);

  always_comb begin
    o_bits = '0;
    for (int s = 0; s < SLICES; s++) begin
      o_bits[s] = i_en &
        (((i_row ^ i_key[s*SLICE_W +: SLICE_W]) & i_mask[s*SLICE_W +: SLICE_W]) == '0);
    end
  end

endmodule

// File: rtl/fractcam_upd.sv
// rtl/fractcam_upd.sv - FracTCAM entry writer: sweeps all 64 LUTRAM rows per update
// Optional FRACTCAM_UPD_SHADOW_EN keeps a readable shadow copy of every entry.
module fractcam_upd
  import fractcam_pkg::*;
#(
  parameter int KEY_WIDTH = 30,
  parameter int DEPTH     = 64,
  parameter int IDX_WIDTH = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst_n,
  fractcam_upd_if.slave upd
);

  localparam int SLICES = slices_of(KEY_WIDTH);
  localparam int PAD_W  = SLICES * SLICE_W;

  upd_state_t           r_state, w_state_nxt;
  logic [SLICE_W-1:0]   r_row;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [KEY_WIDTH-1:0] r_key, r_mask;
  logic                 r_en, r_in_range;
  logic                 w_accept, w_ready, w_busy, w_done, w_in_range;
  logic [PAD_W-1:0]     w_key_pad, w_mask_pad;
  logic [SLICES-1:0]    w_bits;

  assign w_in_range = (int'(upd.wr_index) < DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (upd.wr_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        w_busy = 1'b1;
        if (r_row == SLICE_W'(ROWS - 1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= '0;
      r_idx      <= '0;
      r_key      <= '0;
      r_mask     <= '0;
      r_en       <= 1'b0;
      r_in_range <= 1'b0;
    end else if (w_accept) begin
      r_row      <= '0;
      r_idx      <= upd.wr_index;
      r_key      <= upd.wr_key;
      r_mask     <= upd.wr_mask;
      r_en       <= upd.wr_entry_en;
      r_in_range <= w_in_range;
    end else if (w_busy) begin
      r_row <= r_row + SLICE_W'(1);
    end
  end

  always_comb begin
    w_key_pad                   = '0;
    w_mask_pad                  = {PAD_W{MASK_PAD}};
    w_key_pad[KEY_WIDTH-1:0]    = r_key;
    w_mask_pad[KEY_WIDTH-1:0]   = r_mask;
  end

  fractcam_row_match #(.SLICES(SLICES)) u_row_match (
    .i_row  (r_row),
    .i_key  (w_key_pad),
    .i_mask (w_mask_pad),
    .i_en   (r_en),
    .o_bits (w_bits)
  );

  // Everything below is decoded from registers only; wr_* never reaches the memories directly.
  assign upd.wr_ready = w_ready;
  assign upd.busy     = w_busy;
  assign upd.done     = w_done;
  assign upd.mt_we    = w_busy & r_in_range;
  assign upd.mt_row   = r_row;
  assign upd.mt_col   = r_idx;
  assign upd.mt_data  = w_busy ? w_bits : '0;

`ifdef FRACTCAM_UPD_SHADOW_EN
  logic [DEPTH-1:0]     r_sh_en;
  logic [KEY_WIDTH-1:0] r_sh_key  [DEPTH];
  logic [KEY_WIDTH-1:0] r_sh_mask [DEPTH];
  logic [2*KEY_WIDTH:0] r_rd_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_sh_en <= '0;
    else if (w_accept && w_in_range)  r_sh_en[upd.wr_index] <= upd.wr_entry_en;
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_in_range) begin
      r_sh_key[upd.wr_index]  <= upd.wr_key;
      r_sh_mask[upd.wr_index] <= upd.wr_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_entry <= '0;
    else        r_rd_entry <= {r_sh_en[upd.rd_index], r_sh_key[upd.rd_index], r_sh_mask[upd.rd_index]};
  end

  assign upd.rd_entry = r_rd_entry;
`endif

endmodule

// File: tb/tb_fractcam_upd.sv
// tb/tb_fractcam_upd.sv - directed table-driven bench for fractcam_upd (30-bit and 8-bit key builds)
module tb_fractcam_upd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fractcam_upd_if #(.KEY_WIDTH(30), .DEPTH(64)) if0 ();
  fractcam_upd_if #(.KEY_WIDTH(8),  .DEPTH(48)) if1 ();

  fractcam_upd #(.KEY_WIDTH(30), .DEPTH(64)) u0 (.clk(clk), .rst_n(rst_n), .upd(if0));
  fractcam_upd #(.KEY_WIDTH(8),  .DEPTH(48)) u1 (.clk(clk), .rst_n(rst_n), .upd(if1));

`ifdef FRACTCAM_UPD_SHADOW_EN
  initial begin
    if0.rd_index = '0;
    if1.rd_index = '0;
  end
`endif

  typedef struct {
    int               dut;
    logic [5:0]       idx;
    logic [29:0]      key;
    logic [29:0]      mask;
    logic             en;
    logic             exp_we;
    logic [4:0][63:0] exp;
    string            name;
  } vec_t;

  vec_t vecs[7];
  int   n_assert = 0;
  int   n_fail   = 0;

  logic       s_we, s_busy, s_rdy, s_done;
  logic [5:0] s_row, s_col;
  logic [4:0] s_data;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic sample(input int dut);
    if (dut == 0) begin
      s_we = if0.mt_we; s_busy = if0.busy; s_rdy = if0.wr_ready; s_done = if0.done;
      s_row = if0.mt_row; s_col = if0.mt_col; s_data = if0.mt_data;
    end else begin
      s_we = if1.mt_we; s_busy = if1.busy; s_rdy = if1.wr_ready; s_done = if1.done;
      s_row = if1.mt_row; s_col = if1.mt_col; s_data = {3'b000, if1.mt_data};
    end
  endtask

  task automatic drive(input int dut, input logic v, input logic [5:0] idx,
                       input logic [29:0] key, input logic [29:0] mask, input logic en);
    if (dut == 0) begin
      if0.wr_valid = v; if0.wr_index = idx; if0.wr_key = key; if0.wr_mask = mask; if0.wr_entry_en = en;
    end else begin
      if1.wr_valid = v; if1.wr_index = idx; if1.wr_key = key[7:0]; if1.wr_mask = mask[7:0];
      if1.wr_entry_en = en;
    end
  endtask

  // Called just after the accepting edge; walks the 64 write cycles, the done cycle and the idle cycle.
  task automatic collect(input string nm, input int dut, input logic [5:0] idx, input logic exp_we,
                         output logic [4:0][63:0] bm);
    int errs = 0;
    bm = '0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      sample(dut);
      if (s_we !== exp_we || s_busy !== 1'b1 || s_rdy !== 1'b0 || s_done !== 1'b0 ||
          s_row !== 6'(c - 1) || s_col !== idx) errs++;
      for (int s = 0; s < 5; s++) bm[s][s_row] = s_data[s];
    end
    check({nm, "_sweep_ctl_errs"}, 64'(errs), 64'd0);
    @(negedge clk);
    sample(dut);
    check({nm, "_done_at_65"}, {s_done, s_busy, s_we, s_rdy}, 4'b1000);
    @(negedge clk);
    sample(dut);
    check({nm, "_idle_at_66"}, {s_done, s_busy, s_rdy}, 3'b001);
  endtask

  task automatic check_slices(input string nm, input int nsl,
                              input logic [4:0][63:0] bm, input logic [4:0][63:0] exp);
    for (int s = 0; s < nsl; s++) check($sformatf("%s_slice%0d", nm, s), bm[s], exp[s]);
  endtask

  task automatic run_vec(input vec_t v);
    logic [4:0][63:0] bm;
    drive(v.dut, 1'b1, v.idx, v.key, v.mask, v.en);
    sample(v.dut);
    check({v.name, "_ready"}, s_rdy, 1'b1);
    @(posedge clk);
    #1;
    // Scrambled inputs during the sweep must have no effect.
    drive(v.dut, 1'b0, ~v.idx, ~v.key, ~v.mask, ~v.en);
    collect(v.name, v.dut, v.idx, v.exp_we, bm);
    if (v.exp_we) check_slices(v.name, (v.dut == 0) ? 5 : 2, bm, v.exp);
  endtask

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] R63  = 64'h8000_0000_0000_0000;

  initial begin
    logic [4:0][63:0] bm_a, bm_b;

    vecs[0] = '{0, 6'd5,  30'h0000_003F, 30'h3FFF_FFFF, 1'b1, 1'b1,
                {64'h1, 64'h1, 64'h1, 64'h1, R63}, "exact3f"};
    vecs[1] = '{0, 6'd0,  30'h0000_0000, 30'h0000_0000, 1'b1, 1'b1,
                {ALL1, ALL1, ALL1, ALL1, ALL1}, "wildcard"};
    vecs[2] = '{0, 6'd0,  30'h0000_0000, 30'h0000_0000, 1'b0, 1'b1,
                {64'h0, 64'h0, 64'h0, 64'h0, 64'h0}, "invalidate"};
    vecs[3] = '{0, 6'd7,  30'h0000_002A, 30'h0000_0030, 1'b1, 1'b1,
                {ALL1, ALL1, ALL1, ALL1, 64'h0000_FFFF_0000_0000}, "partial_mask"};
    vecs[4] = '{0, 6'd63, 30'h3FFF_FFFF, 30'h3FFF_FFFF, 1'b1, 1'b1,
                {R63, R63, R63, R63, R63}, "all_ones_idx63"};
    vecs[5] = '{1, 6'd3,  30'h0000_00FF, 30'h0000_00FF, 1'b1, 1'b1,
                {64'h0, 64'h0, 64'h0, 64'h8888_8888_8888_8888, R63}, "k8_pad"};
    vecs[6] = '{1, 6'd50, 30'h0000_0000, 30'h0000_0000, 1'b1, 1'b0,
                {64'h0, 64'h0, 64'h0, 64'h0, 64'h0}, "k8_idx_oob"};

    drive(0, 1'b0, 6'd0, 30'd0, 30'd0, 1'b0);
    drive(1, 1'b0, 6'd0, 30'd0, 30'd0, 1'b0);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sample(d);
      check($sformatf("reset_state_dut%0d", d),
            {s_rdy, s_busy, s_we, s_done, s_row, s_col, s_data}, {4'b1000, 6'd0, 6'd0, 5'd0});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: valid held high, second request swapped in mid-sweep and accepted at N+66.
    drive(0, 1'b1, 6'd9, 30'h0, 30'h3F, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 6'd10, 30'h15, 30'h3F, 1'b1);
    collect("b2b_a", 0, 6'd9, 1'b1, bm_a);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 6'd0, 30'h0, 30'h0, 1'b0);
    collect("b2b_b", 0, 6'd10, 1'b1, bm_b);
    check_slices("b2b_a", 5, bm_a, {ALL1, ALL1, ALL1, ALL1, 64'h1});
    check_slices("b2b_b", 5, bm_b, {ALL1, ALL1, ALL1, ALL1, 64'h0000_0000_0020_0000});

    // Reset at row 30 aborts immediately; the reissued update then completes normally.
    drive(0, 1'b1, 6'd12, 30'h0, 30'h0, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 6'd0, 30'h0, 30'h0, 1'b0);
    repeat (31) @(negedge clk);
    sample(0);
    check("rst_mid_row30", {s_busy, s_row, s_col}, {1'b1, 6'd30, 6'd12});
    rst_n = 1'b0;
    #1;
    sample(0);
    check("rst_mid_outputs", {s_rdy, s_busy, s_we, s_done, s_row, s_col, s_data},
          {4'b1000, 6'd0, 6'd0, 5'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sample(0);
    check("rst_release_ready", {s_rdy, s_busy}, 2'b10);
    run_vec('{0, 6'd12, 30'h0, 30'h0, 1'b1, 1'b1, {ALL1, ALL1, ALL1, ALL1, ALL1}, "reissue"});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
